ir_fetch: RTL and testbench

- Instruction fetch unit: the writer side of the shared 64-bit instruction bus that the instruction register captures from.
- On command from the control unit it reads one eBPF instruction slot from instruction memory in two 32-bit beats, drives it onto ir_bus and pulses ir_load, then advances the PC.
- LDDW (opcode 0x18) is fetched as two slots; the second slot's upper immediate is presented on a side port.

---
 rtl/ir_fetch_if.sv | 29 ++
 rtl/ir_fetch.sv | 215 +++++++++++++++++++++
 tb/tb_ir_fetch.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_fetch_if.sv
// ir_fetch_if - instruction memory read channel between the fetch unit and
// instruction memory.
//
//   mem_req    master -> slave  beat request, held until mem_ack
//   mem_addr   master -> slave  32-bit word address {slot, beat}
//   mem_ack    slave -> master  beat accepted; mem_rdata valid in the same cycle
//   mem_rdata  slave -> master  read data
interface ir_fetch_if #(
   parameter int ADDR_W = 16
) ();
   logic              mem_req;
   logic [ADDR_W:0]   mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/ir_fetch.sv
// ir_fetch - instruction fetch unit, writer side of the shared 64-bit
// instruction bus. On fetch_start it reads one eBPF slot in two 32-bit beats,
// drives it onto ir_bus with a one-cycle ir_load, then advances the PC.
// LDDW (opcode 0x18) also fetches the following slot; that slot's high word
// is presented on imm_hi.
//
// Build option: define IFETCH_TIMEOUT_EN to add a per-beat wait limit
// (TIMEOUT_CYC) and the fetch_err pulse output.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   fetch_start    one-cycle fetch request, accepted only when idle
//   pc_load/pc_in  branch target load; deferred to completion while busy
//   pc             current PC in 8-byte slots
//   mem            instruction memory read channel (ir_fetch_if.master)
//   ir_valid       instruction register currently owns ir_bus
//   ir_load        capture strobe to the instruction register
//   ir_bus         shared 64-bit instruction bus (driven only with ir_load)
//   imm_hi/_valid  LDDW upper immediate
//   busy           high whenever not idle
//   fetch_done     one-cycle completion pulse
//   fetch_err      one-cycle timeout pulse (IFETCH_TIMEOUT_EN only)
//
// state  | meaning
// IDLE   | waiting for fetch_start
// LO     | requesting low word of slot pc
// HI     | requesting high word of slot pc
// DRIVE  | waiting for ir_valid low, then drive ir_bus for one cycle
// X_LO   | LDDW: low word of slot pc+1 (discarded)
// X_HI   | LDDW: high word of slot pc+1 -> imm_hi
// DONE   | fetch_done pulse, PC update
module ir_fetch #(
   parameter int ADDR_W = 16
`ifdef IFETCH_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc,
   ir_fetch_if.master        mem,
   input  logic              ir_valid,
   output logic              ir_load,
   inout  tri   [63:0]       ir_bus,
   output logic [31:0]       imm_hi,
   output logic              imm_hi_valid,
   output logic              busy,
   output logic              fetch_done
`ifdef IFETCH_TIMEOUT_EN
   , output logic            fetch_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DRIVE,
      S_X_LO,
      S_X_HI,
      S_DONE
   } state_t;

   state_t            state;
   logic [63:0]       word_q;
   logic              pend_q;
   logic [ADDR_W-1:0] pend_pc;
   logic [ADDR_W-1:0] pc_nxt1;
   logic [ADDR_W-1:0] pc_nxt2;
   logic              is_lddw;
   logic              drive_go;

`ifdef IFETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]  wait_cnt;
`endif

   assign pc_nxt1 = pc + ADDR_W'(1);
   assign pc_nxt2 = pc + ADDR_W'(2);
   assign is_lddw = (word_q[7:0] == 8'h18);

   // The bus grant is gated combinationally by ir_valid so the unit can never
   // overlap the instruction register on ir_bus, even if ir_valid rises in the
   // very cycle the word would otherwise be driven.
   assign drive_go = (state == S_DRIVE) && !ir_valid;
   assign ir_load  = drive_go;
   assign ir_bus   = drive_go ? word_q : 64'bz;
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         pc           <= '0;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         word_q       <= '0;
         pend_q       <= 1'b0;
         pend_pc      <= '0;
         imm_hi       <= '0;
         imm_hi_valid <= 1'b0;
         fetch_done   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         fetch_err    <= 1'b0;
         wait_cnt     <= '0;
`endif
      end else begin
         fetch_done <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         fetch_err  <= 1'b0;
`endif

         // Branch while busy: remember the latest target; DONE applies it.
         if (state != S_IDLE && pc_load) begin
            pend_q  <= 1'b1;
            pend_pc <= pc_in;
         end

         case (state)
            S_IDLE: begin
               if (pc_load) begin
                  pc     <= pc_in;
                  pend_q <= 1'b0;
               end
               if (fetch_start) begin
                  state        <= S_LO;
                  mem.mem_req  <= 1'b1;
                  mem.mem_addr <= {(pc_load ? pc_in : pc), 1'b0};
                  imm_hi_valid <= 1'b0;
               end
            end

            S_LO: begin
               if (mem.mem_ack) begin
                  word_q[31:0] <= mem.mem_rdata;
                  mem.mem_addr <= {pc, 1'b1};
                  state        <= S_HI;
               end
            end

            S_HI: begin
               if (mem.mem_ack) begin
                  word_q[63:32] <= mem.mem_rdata;
                  mem.mem_req   <= 1'b0;
                  state         <= S_DRIVE;
               end
            end

            S_DRIVE: begin
               if (!ir_valid) begin
                  if (is_lddw) begin
                     mem.mem_req  <= 1'b1;
                     mem.mem_addr <= {pc_nxt1, 1'b0};
                     state        <= S_X_LO;
                  end else begin
                     fetch_done <= 1'b1;
                     state      <= S_DONE;
                  end
               end
            end

            S_X_LO: begin
               if (mem.mem_ack) begin
                  mem.mem_addr <= {pc_nxt1, 1'b1};
                  state        <= S_X_HI;
               end
            end

            S_X_HI: begin
               if (mem.mem_ack) begin
                  imm_hi       <= mem.mem_rdata;
                  imm_hi_valid <= 1'b1;
                  mem.mem_req  <= 1'b0;
                  fetch_done   <= 1'b1;
                  state        <= S_DONE;
               end
            end

            S_DONE: begin
               // A branch arriving in this very cycle is newer than any latched one.
               if (pc_load)     pc <= pc_in;
               else if (pend_q) pc <= pend_pc;
               else if (is_lddw) pc <= pc_nxt2;
               else             pc <= pc_nxt1;
               pend_q <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               mem.mem_req <= 1'b0;
               state       <= S_IDLE;
            end
         endcase

`ifdef IFETCH_TIMEOUT_EN
         // Placed after the case so an expiry overrides the beat handshake.
         if (mem.mem_req && !mem.mem_ack) begin
            if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               fetch_err   <= 1'b1;
               mem.mem_req <= 1'b0;
               state       <= S_IDLE;
               wait_cnt    <= '0;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
         end else begin
            wait_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ir_fetch.sv
module tb_ir_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic        pc_load;
   logic [15:0] pc_in;
   logic [15:0] pc;
   logic        ir_valid;
   logic        ir_load;
   tri   [63:0] ir_bus;
   logic [31:0] imm_hi;
   logic        imm_hi_valid;
   logic        busy;
   logic        fetch_done;
`ifdef IFETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   ir_fetch_if #(.ADDR_W(16)) mem_if ();

   ir_fetch #(.ADDR_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_start  (fetch_start),
      .pc_load      (pc_load),
      .pc_in        (pc_in),
      .pc           (pc),
      .mem          (mem_if),
      .ir_valid     (ir_valid),
      .ir_load      (ir_load),
      .ir_bus       (ir_bus),
      .imm_hi       (imm_hi),
      .imm_hi_valid (imm_hi_valid),
      .busy         (busy),
      .fetch_done   (fetch_done)
`ifdef IFETCH_TIMEOUT_EN
      , .fetch_err  (fetch_err)
`endif
   );

   always #5 clk = ~clk;

   // Bus keeper standing in for the rest of the bus: pulls ir_bus to zero
   // whenever the fetch unit is not granted, so any stray drive shows up.
   assign ir_bus = ir_load ? 64'bz : 64'h0;

   // Instruction memory model: a base slot with lo/hi words, and the high word
   // of any other slot returns xhi_w.
   logic        ack_en = 1'b1;
   logic        wait_mode = 1'b0;
   logic        ack_hold_lo = 1'b0;
   logic [15:0] base_slot = '0;
   logic [31:0] lo_w = '0, hi_w = '0, xhi_w = '0;
   logic [15:0] rd_slot;

   assign rd_slot          = mem_if.mem_addr[16:1];
   assign mem_if.mem_ack   = mem_if.mem_req & ack_en;
   assign mem_if.mem_rdata = (rd_slot == base_slot) ? (mem_if.mem_addr[0] ? hi_w : lo_w)
                                                    : (mem_if.mem_addr[0] ? xhi_w : 32'h0BAD_F00D);

   always @(posedge clk)
      ack_en <= ack_hold_lo ? 1'b0 : (wait_mode ? ($urandom_range(0, 1) == 1) : 1'b1);

   // Scoreboard
   typedef struct {
      logic        lddw;
      logic [31:0] imm;
      logic [15:0] pc_after;
      int          lat;
      int          start;
   } done_t;

   logic [16:0] exp_addr[$];
   logic [63:0] exp_word[$];
   done_t       exp_done[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_start = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor
   logic        pc_chk_pend = 1'b0;
   logic [15:0] pc_chk_val  = '0;

   always @(negedge clk) begin
      done_t d;
      cyc++;
      if (pc_chk_pend) begin
         chk("pc_after_fetch", pc, pc_chk_val);
         pc_chk_pend = 1'b0;
      end
      if (!rst) begin
         if (mem_if.mem_req && mem_if.mem_ack) begin
            if (exp_addr.size() == 0) chk("unexpected_beat", mem_if.mem_addr, 17'h1_FFFF);
            else chk("mem_addr", mem_if.mem_addr, exp_addr.pop_front());
         end
         if (ir_load) begin
            chk("ir_valid_low_on_load", ir_valid, 1'b0);
            if (exp_word.size() == 0) chk("unexpected_ir_load", ir_bus, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("ir_bus_word", ir_bus, exp_word.pop_front());
         end else if (ir_bus !== 64'h0) begin
            chk("ir_bus_released", ir_bus, 64'h0);
         end
         if (fetch_done) begin
            if (exp_done.size() == 0) chk("unexpected_fetch_done", fetch_done, 1'b0);
            else begin
               d = exp_done.pop_front();
               chk("imm_hi_valid", imm_hi_valid, d.lddw);
               if (d.lddw) chk("imm_hi", imm_hi, d.imm);
               if (d.lat > 0) chk("fetch_latency", cyc - d.start, d.lat);
               pc_chk_pend = 1'b1;
               pc_chk_val  = d.pc_after;
            end
         end
      end
   end

   // Stimulus helpers
   task automatic start_fetch(input logic with_load, input logic [15:0] val);
      @(posedge clk); #1;
      fetch_start = 1'b1;
      pc_load     = with_load;
      pc_in       = val;
      last_start  = cyc + 1;
      @(posedge clk); #1;
      fetch_start = 1'b0;
      pc_load     = 1'b0;
   endtask

   task automatic push_done(input logic lddw, input logic [31:0] imm,
                            input logic [15:0] pc_after, input int lat);
      done_t d;
      d.lddw = lddw; d.imm = imm; d.pc_after = pc_after; d.lat = lat; d.start = last_start;
      exp_done.push_back(d);
   endtask

   task automatic finish_fetch();
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (fetch_done) seen = 1;
      end
      if (!seen) chk("fetch_done_timeout", 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic set_mem(input logic [15:0] slot, input logic [31:0] lo,
                          input logic [31:0] hi, input logic [31:0] xhi);
      base_slot = slot; lo_w = lo; hi_w = hi; xhi_w = xhi;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_in = '0; ir_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", pc, 16'h0);
      chk("rst_mem_req", mem_if.mem_req, 1'b0);
      chk("rst_ir_load", ir_load, 1'b0);
      chk("rst_ir_bus", ir_bus, 64'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fetch_done", fetch_done, 1'b0);
      chk("rst_imm_hi_valid", imm_hi_valid, 1'b0);
      chk("rst_imm_hi", imm_hi, 32'h0);
      rst = 1'b0;

      // 1: pc_load 5, then a plain fetch with zero-wait memory.
      @(posedge clk); #1; pc_load = 1'b1; pc_in = 16'd5;
      @(posedge clk); #1; pc_load = 1'b0;
      chk("pc_load_idle", pc, 16'd5);
      set_mem(16'd5, 32'h0000_00B7, 32'h0000_002A, 32'h0);
      exp_addr.push_back(17'd10); exp_addr.push_back(17'd11);
      exp_word.push_back(64'h0000_002A_0000_00B7);
      start_fetch(1'b0, 16'd0);
      push_done(1'b0, 32'h0, 16'd6, 4);
      finish_fetch();

      // 2: LDDW at pc 3, pc_load in the same cycle as fetch_start.
      set_mem(16'd3, 32'h0000_0018, 32'h0000_0000, 32'hDEAD_BEEF);
      exp_addr.push_back(17'd6); exp_addr.push_back(17'd7);
      exp_addr.push_back(17'd8); exp_addr.push_back(17'd9);
      exp_word.push_back(64'h0000_0000_0000_0018);
      start_fetch(1'b1, 16'd3);
      push_done(1'b1, 32'hDEAD_BEEF, 16'd5, 6);
      finish_fetch();

      // 3: ir_valid high for the first three DRIVE cycles.
      set_mem(16'd5, 32'h0000_0011, 32'h0000_0022, 32'h0);
      exp_addr.push_back(17'd10); exp_addr.push_back(17'd11);
      exp_word.push_back(64'h0000_0022_0000_0011);
      ir_valid = 1'b1;
      start_fetch(1'b0, 16'd0);
      push_done(1'b0, 32'h0, 16'd6, 7);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_ir_load_low", ir_load, 1'b0);
         chk("hold_busy", busy, 1'b1);
      end
      @(posedge clk); #1; ir_valid = 1'b0;
      @(negedge clk);
      chk("drive_after_ir_valid_falls", ir_load, 1'b1);
      finish_fetch();

      // 4: PC wrap from the last slot.
      set_mem(16'hFFFF, 32'h0000_0095, 32'h0000_0001, 32'h0);
      exp_addr.push_back(17'h1_FFFE); exp_addr.push_back(17'h1_FFFF);
      exp_word.push_back(64'h0000_0001_0000_0095);
      start_fetch(1'b1, 16'hFFFF);
      push_done(1'b0, 32'h0, 16'd0, 4);
      finish_fetch();

      // 5: branch during HI is deferred to completion.
      set_mem(16'd0, 32'h0000_0033, 32'h0000_0044, 32'h0);
      exp_addr.push_back(17'd0); exp_addr.push_back(17'd1);
      exp_word.push_back(64'h0000_0044_0000_0033);
      start_fetch(1'b0, 16'd0);
      push_done(1'b0, 32'h0, 16'd20, 4);
      @(posedge clk); #1; pc_load = 1'b1; pc_in = 16'd20;
      @(posedge clk); #1; pc_load = 1'b0;
      chk("pc_held_while_busy", pc, 16'd0);
      fetch_start = 1'b1;
      @(posedge clk); #1; fetch_start = 1'b0;
      finish_fetch();

      // 6: LDDW at pc 20 with random memory wait states.
      wait_mode = 1'b1;
      set_mem(16'd20, 32'hCAFE_0018, 32'h1234_5678, 32'h8765_4321);
      exp_addr.push_back(17'd40); exp_addr.push_back(17'd41);
      exp_addr.push_back(17'd42); exp_addr.push_back(17'd43);
      exp_word.push_back(64'h1234_5678_CAFE_0018);
      start_fetch(1'b0, 16'd0);
      push_done(1'b1, 32'h8765_4321, 16'd22, 0);
      finish_fetch();
      wait_mode = 1'b0;
      @(posedge clk); #1;

      // 7: asynchronous reset in the middle of X_LO.
      set_mem(16'd22, 32'h0000_0018, 32'h0000_0000, 32'h5555_AAAA);
      exp_addr.push_back(17'd44); exp_addr.push_back(17'd45);
      exp_word.push_back(64'h0000_0000_0000_0018);
      start_fetch(1'b0, 16'd0);
      repeat (3) @(posedge clk);
      #2;
      chk("xlo_req_before_rst", mem_if.mem_req, 1'b1);
      chk("xlo_addr_before_rst", mem_if.mem_addr, 17'd46);
      rst = 1'b1;
      #1;
      chk("rst_mid_mem_req", mem_if.mem_req, 1'b0);
      chk("rst_mid_ir_bus", ir_bus, 64'h0);
      chk("rst_mid_pc", pc, 16'd0);
      chk("rst_mid_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;

`ifdef IFETCH_TIMEOUT_EN
      // 8: memory never acks; fetch_err after 255 wait cycles, pc unchanged.
      begin
         bit seen_err = 0;
         int err_cyc = 0;
         ack_hold_lo = 1'b1;
         @(posedge clk); #1; pc_load = 1'b1; pc_in = 16'd7;
         @(posedge clk); #1; pc_load = 1'b0;
         start_fetch(1'b0, 16'd0);
         for (int i = 0; i < 400 && !seen_err; i++) begin
            @(negedge clk);
            if (fetch_err) begin seen_err = 1; err_cyc = cyc; end
         end
         chk("fetch_err_seen", seen_err, 1'b1);
         chk("fetch_err_latency", err_cyc - last_start, 256);
         chk("timeout_mem_req", mem_if.mem_req, 1'b0);
         @(negedge clk);
         chk("timeout_pc", pc, 16'd7);
         chk("timeout_busy", busy, 1'b0);
         ack_hold_lo = 1'b0;
      end
`endif

      repeat (3) @(negedge clk);
      chk("addr_queue_empty", exp_addr.size(), 0);
      chk("word_queue_empty", exp_word.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
